bytewrite_tdp_ram_modal: RTL and testbench
==========================================

// Module: bytewrite_tdp_ram_modal
// PURPOSE
//  Single-clock true-dual-port RAM with per-column byte-write enables and a
//  per-port selectable write mode (READ_FIRST / WRITE_FIRST / NO_CHANGE).
//  Optional output pipeline register, per-port read-valid strobes, and
//  same-address write-collision detection with deterministic arbitration.
//  Next-generation general-purpose block RAM for datapath buffers; maps to BRAM.
// PARAMETERS
//  NUM_COL     4            columns (byte lanes) per word
//  COL_WIDTH   8            bits per column
//  ADDR_WIDTH  10           address bits; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  NUM_COL*COL_WIDTH  word width (derived, do not override)
//  MODE_A      0            port A write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
//  MODE_B      0            port B write mode, same encoding
//  OUT_REG     0            1 = extra output register stage (read latency 2)
// PORTS
//  clk        in   1            sole clock, all logic on rising edge
//  rst_n      in   1            asynchronous active-low reset
//  enaA       in   1            port A access enable
//  weA        in   NUM_COL      port A column write enables (qualified by enaA)
//  addrA      in   ADDR_WIDTH   port A address
//  dinA       in   DATA_WIDTH   port A write data
//  doutA      out  DATA_WIDTH   port A read data
//  validA     out  1            doutA updated with a new read this cycle
//  enaB/weB/addrB/dinB/doutB/validB   as port A, for port B
//  collision  out  1            1-cycle pulse: same-address overlapping write
// BEHAVIOUR
//  Reset: doutA, doutB, validA, validB, collision, pipeline regs -> 0 immediately
//   on rst_n low; memory contents NOT reset. Deasserting rst_n mid-operation
//   leaves all accesses issued before reset unreported (valid stays 0).
//  Write: enaX & weX[i] -> column i of mem[addrX] <= dinX column i at edge.
//  Read latency L = 1 + OUT_REG cycles from enaX sample to doutX/validX.
//  validX = enaX delayed L cycles, masked in NO_CHANGE when weX != 0.
//  Port read data per mode (same-port, same-cycle write):
//   READ_FIRST : doutX = mem[addrX] before the write.
//   WRITE_FIRST: doutX = merge: column i = dinX col i if weX[i] else old col i.
//   NO_CHANGE  : any weX bit set -> doutX holds, validX stays 0; else reads.
//  enaX=0 -> doutX holds, validX=0. Output stage (OUT_REG=1) only loads when
//   its input stage is valid; otherwise holds.
//  Cross-port, same cycle, same address: reader gets OLD data for columns the
//   other port writes (READ_FIRST between ports, regardless of MODE).
//  Collision: enaA & enaB & addrA==addrB & |(weA&weB) -> collision=1 next
//   cycle (not delayed by OUT_REG). Overlapping columns take port A data;
//   non-overlapping columns take their own writer. Disjoint columns at same
//   address -> no collision, both written.
//  Address wrap: none; all 2**ADDR_WIDTH words addressable, no range checks.
//  Back-to-back accesses every cycle supported on both ports (full throughput).
// TESTING
//  1. Reset: rst_n=0 async mid-cycle -> doutA/B=0, validA/B=0, collision=0
//     before next edge; pre-written mem[5]=0xDEADBEEF still reads back after.
//  2. READ_FIRST A: mem[3]=0x11223344, write weA=4'b0011 dinA=0xAAAABBBB
//     addr 3 -> doutA=0x11223344, validA=1 at L; next read gives 0x1122BBBB.
//  3. WRITE_FIRST A same stimulus -> doutA=0x1122BBBB at L; NO_CHANGE ->
//     doutA keeps prior value, validA=0.
//  4. Collision: addr 7 both ports, weA=4'b0011 dinA=0x0000AAAA, weB=4'b0110
//     dinB=0x00BBBB00 -> collision pulse 1 cycle; mem[7] cols = {old,BB,AA,AA}.
//  5. Cross-port: mem[9]=0x1; A writes 0x2, B reads addr 9 same cycle ->
//     doutB=0x1; B reads again -> 0x2. Repeat with OUT_REG=1: latency 2.
//  6. Streaming: 1024 consecutive writes on A then reads on B with
//     random enaB gaps -> every validB matches scoreboard, incl. addr 0/1023.

Source files
------------

// File: rtl/bytewrite_tdp_ram_modal.sv
// Single-clock true-dual-port RAM with byte-column write enables, per-port write mode
// (read-first / write-first / no-change), optional output register and collision flag.
module bytewrite_tdp_ram_modal #(
   parameter int unsigned NUM_COL    = 4,
   parameter int unsigned COL_WIDTH  = 8,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
   parameter int unsigned MODE_A     = 0,
   parameter int unsigned MODE_B     = 0,
   parameter int unsigned OUT_REG    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enaA,
   input  logic [NUM_COL-1:0]    weA,
   input  logic [ADDR_WIDTH-1:0] addrA,
   input  logic [DATA_WIDTH-1:0] dinA,
   output logic [DATA_WIDTH-1:0] doutA,
   output logic                  validA,
   input  logic                  enaB,
   input  logic [NUM_COL-1:0]    weB,
   input  logic [ADDR_WIDTH-1:0] addrB,
   input  logic [DATA_WIDTH-1:0] dinB,
   output logic [DATA_WIDTH-1:0] doutB,
   output logic                  validB,
   output logic                  collision
);

   localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH;
   localparam int unsigned ModeWriteFirst = 1;
   localparam int unsigned ModeNoChange   = 2;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [NUM_COL-1:0]    wr_a, wr_b;
   logic                  ld_a, ld_b;
   logic [DATA_WIDTH-1:0] rd_a, rd_b;
   logic [DATA_WIDTH-1:0] dout1_a_q, dout1_a_d, dout1_b_q, dout1_b_d;
   logic                  val1_a_q, val1_a_d, val1_b_q, val1_b_d;
   logic                  collision_q, collision_d;

   always_comb begin
      wr_a = enaA ? weA : '0;
      wr_b = enaB ? weB : '0;
      ld_a = enaA && !((MODE_A == ModeNoChange) && (|weA));
      ld_b = enaB && !((MODE_B == ModeNoChange) && (|weB));
      // Array read happens before the edge, so the other port always sees old data.
      rd_a = mem[addrA];
      rd_b = mem[addrB];
      for (int i = 0; i < NUM_COL; i++) begin
         if ((MODE_A == ModeWriteFirst) && wr_a[i]) begin
            rd_a[i*COL_WIDTH +: COL_WIDTH] = dinA[i*COL_WIDTH +: COL_WIDTH];
         end
         if ((MODE_B == ModeWriteFirst) && wr_b[i]) begin
            rd_b[i*COL_WIDTH +: COL_WIDTH] = dinB[i*COL_WIDTH +: COL_WIDTH];
         end
      end
      dout1_a_d   = ld_a ? rd_a : dout1_a_q;
      dout1_b_d   = ld_b ? rd_b : dout1_b_q;
      val1_a_d    = ld_a;
      val1_b_d    = ld_b;
      collision_d = enaA && enaB && (addrA == addrB) && (|(weA & weB));
   end

   // Port A is written last so it owns overlapping columns on a collision.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_COL; i++) begin
         if (wr_b[i]) mem[addrB][i*COL_WIDTH +: COL_WIDTH] <= dinB[i*COL_WIDTH +: COL_WIDTH];
         if (wr_a[i]) mem[addrA][i*COL_WIDTH +: COL_WIDTH] <= dinA[i*COL_WIDTH +: COL_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout1_a_q   <= '0;
         dout1_b_q   <= '0;
         val1_a_q    <= 1'b0;
         val1_b_q    <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         dout1_a_q   <= dout1_a_d;
         dout1_b_q   <= dout1_b_d;
         val1_a_q    <= val1_a_d;
         val1_b_q    <= val1_b_d;
         collision_q <= collision_d;
      end
   end

   assign collision = collision_q;

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] dout2_a_q, dout2_a_d, dout2_b_q, dout2_b_d;
      logic                  val2_a_q, val2_a_d, val2_b_q, val2_b_d;

      always_comb begin
         dout2_a_d = val1_a_q ? dout1_a_q : dout2_a_q;
         dout2_b_d = val1_b_q ? dout1_b_q : dout2_b_q;
         val2_a_d  = val1_a_q;
         val2_b_d  = val1_b_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout2_a_q <= '0;
            dout2_b_q <= '0;
            val2_a_q  <= 1'b0;
            val2_b_q  <= 1'b0;
         end else begin
            dout2_a_q <= dout2_a_d;
            dout2_b_q <= dout2_b_d;
            val2_a_q  <= val2_a_d;
            val2_b_q  <= val2_b_d;
         end
      end

      assign doutA  = dout2_a_q;
      assign doutB  = dout2_b_q;
      assign validA = val2_a_q;
      assign validB = val2_b_q;
   end else begin : g_no_out_reg
      assign doutA  = dout1_a_q;
      assign doutB  = dout1_b_q;
      assign validA = val1_a_q;
      assign validB = val1_b_q;
   end

endmodule

// File: tb/tb_bytewrite_tdp_ram_modal.sv
// Bench for bytewrite_tdp_ram_modal: four instances share stimulus
// (0 read-first, 1 write-first, 2 no-change, 3 read-first with output register).
module tb_bytewrite_tdp_ram_modal;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena_a, ena_b;
   logic [3:0]  we_a, we_b;
   logic [9:0]  addr_a, addr_b;
   logic [31:0] din_a, din_b;
   logic [31:0] dout_a [4];
   logic [31:0] dout_b [4];
   logic [3:0]  val_a, val_b, coll;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_mem [1024];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      bytewrite_tdp_ram_modal #(
         .NUM_COL   (4),
         .COL_WIDTH (8),
         .ADDR_WIDTH(10),
         .MODE_A    ((g == 3) ? 0 : g),
         .MODE_B    ((g == 3) ? 0 : g),
         .OUT_REG   ((g == 3) ? 1 : 0)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .enaA     (ena_a),
         .weA      (we_a),
         .addrA    (addr_a),
         .dinA     (din_a),
         .doutA    (dout_a[g]),
         .validA   (val_a[g]),
         .enaB     (ena_b),
         .weB      (we_b),
         .addrB    (addr_b),
         .dinB     (din_b),
         .doutB    (dout_b[g]),
         .validB   (val_b[g]),
         .collision(coll[g])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ea, input logic [3:0] wa, input logic [9:0] aa,
                        input logic [31:0] da, input logic eb, input logic [3:0] wb,
                        input logic [9:0] ab, input logic [31:0] db);
      ena_a = ea; we_a = wa; addr_a = aa; din_a = da;
      ena_b = eb; we_b = wb; addr_b = ab; din_b = db;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   rd_addr;
      int   drain;
      logic en, v1, v2;
      logic [9:0] a1, a2;

      rst_n = 1'b0;
      idle();
      #2;
      check_eq("rst0_doutA", dout_a[0], 32'h0);
      check_eq("rst0_validA", {31'h0, val_a[0]}, 32'h0);
      check_eq("rst0_coll", {31'h0, coll[0]}, 32'h0);
      check_eq("rst0_or_doutB", dout_b[3], 32'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // mem[5] full write by A, overlapping col 0 by B; then async reset mid-cycle
      drive(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b1, 4'h1, 10'd5, 32'h000000EF);
      tick();
      idle();
      check_eq("m5_coll", {31'h0, coll[0]}, 32'h1);
      check_eq("m5_or_coll", {31'h0, coll[3]}, 32'h1);
      check_eq("m5_rf_validA", {31'h0, val_a[0]}, 32'h1);
      check_eq("m5_nc_validA", {31'h0, val_a[2]}, 32'h0);
      check_eq("m5_wf_doutA", dout_a[1], 32'hDEADBEEF);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_doutA", dout_a[1], 32'h0);
      check_eq("arst_validA", {31'h0, val_a[0]}, 32'h0);
      check_eq("arst_coll", {31'h0, coll[0]}, 32'h0);
      #1;
      rst_n = 1'b1;

      drive(1'b1, 4'h0, 10'd5, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
      tick();
      idle();
      check_eq("m5_rd_doutA", dout_a[0], 32'hDEADBEEF);
      check_eq("m5_rd_validA", {31'h0, val_a[0]}, 32'h1);
      check_eq("m5_or_validA_L1", {31'h0, val_a[3]}, 32'h0);
      tick();
      check_eq("m5_or_doutA_L2", dout_a[3], 32'hDEADBEEF);
      check_eq("m5_or_validA_L2", {31'h0, val_a[3]}, 32'h1);
      check_eq("m5_hold_doutA", dout_a[0], 32'hDEADBEEF);
      check_eq("m5_idle_validA", {31'h0, val_a[0]}, 32'h0);

      // Same-port partial write in each mode
      drive(1'b1, 4'hF, 10'd3, 32'h11223344, 1'b0, 4'h0, 10'd0, 32'h0);
      tick();
      drive(1'b1, 4'h3, 10'd3, 32'hAAAABBBB, 1'b0, 4'h0, 10'd0, 32'h0);
      tick();
      check_eq("rf_doutA", dout_a[0], 32'h11223344);
      check_eq("rf_validA", {31'h0, val_a[0]}, 32'h1);
      check_eq("wf_doutA", dout_a[1], 32'h1122BBBB);
      check_eq("wf_validA", {31'h0, val_a[1]}, 32'h1);
      check_eq("nc_doutA", dout_a[2], 32'hDEADBEEF);
      check_eq("nc_validA", {31'h0, val_a[2]}, 32'h0);
      drive(1'b1, 4'h0, 10'd3, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
      tick();
      check_eq("rf_reread", dout_a[0], 32'h1122BBBB);
      check_eq("nc_reread", dout_a[2], 32'h1122BBBB);

      // Collision with overlapping column 1, then disjoint columns
      drive(1'b1, 4'hF, 10'd7, 32'h12345678, 1'b0, 4'h0, 10'd0, 32'h0);
      tick();
      drive(1'b1, 4'h3, 10'd7, 32'h0000AAAA, 1'b1, 4'h6, 10'd7, 32'h00BBBB00);
      tick();
      check_eq("col_pulse", {31'h0, coll[0]}, 32'h1);
      check_eq("col_or_pulse", {31'h0, coll[3]}, 32'h1);
      check_eq("col_rf_doutA", dout_a[0], 32'h12345678);
      check_eq("col_rf_doutB", dout_b[0], 32'h12345678);
      idle();
      tick();
      check_eq("col_pulse_end", {31'h0, coll[0]}, 32'h0);
      drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd7, 32'h0);
      tick();
      check_eq("col_mem7", dout_b[0], 32'h12BBAAAA);
      drive(1'b1, 4'h1, 10'd7, 32'h00000011, 1'b1, 4'h8, 10'd7, 32'h99000000);
      tick();
      check_eq("disj_no_coll", {31'h0, coll[0]}, 32'h0);
      drive(1'b1, 4'h0, 10'd7, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
      tick();
      check_eq("disj_mem7", dout_a[0], 32'h99BBAA11);

      // Cross-port: B reads the address A is writing
      drive(1'b1, 4'hF, 10'd9, 32'h1, 1'b0, 4'h0, 10'd0, 32'h0);
      tick();
      drive(1'b1, 4'hF, 10'd9, 32'h2, 1'b1, 4'h0, 10'd9, 32'h0);
      tick();
      check_eq("xp_rf_doutB", dout_b[0], 32'h1);
      check_eq("xp_rf_validB", {31'h0, val_b[0]}, 32'h1);
      check_eq("xp_wf_doutB", dout_b[1], 32'h1);
      check_eq("xp_or_validB_L1", {31'h0, val_b[3]}, 32'h0);
      drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0);
      tick();
      idle();
      check_eq("xp_rf_reread", dout_b[0], 32'h2);
      check_eq("xp_or_doutB_L2", dout_b[3], 32'h1);
      check_eq("xp_or_validB_L2", {31'h0, val_b[3]}, 32'h1);
      tick();
      check_eq("xp_or_reread", dout_b[3], 32'h2);
      check_eq("xp_or_validB", {31'h0, val_b[3]}, 32'h1);
      check_eq("xp_rf_idle_validB", {31'h0, val_b[0]}, 32'h0);

      // Streaming: fill all words via A, read back via B with random gaps
      for (int i = 0; i < 1024; i++) begin
         exp_mem[i] = $urandom;
         drive(1'b1, 4'hF, 10'(i), exp_mem[i], 1'b0, 4'h0, 10'd0, 32'h0);
         tick();
      end
      idle();
      tick();
      rd_addr = 0;
      drain   = 0;
      v1 = 1'b0; v2 = 1'b0; a1 = '0; a2 = '0;
      for (int c = 0; c < 6000 && drain < 3; c++) begin
         en = (rd_addr < 1024) && ($urandom_range(0, 3) != 0);
         drive(1'b0, 4'h0, 10'd0, 32'h0, en, 4'h0, 10'(rd_addr), 32'h0);
         tick();
         v2 = v1; a2 = a1;
         v1 = en; a1 = 10'(rd_addr);
         check_eq("strm_validB", {31'h0, val_b[0]}, {31'h0, v1});
         if (v1) check_eq("strm_doutB", dout_b[0], exp_mem[a1]);
         check_eq("strm_or_validB", {31'h0, val_b[3]}, {31'h0, v2});
         if (v2) check_eq("strm_or_doutB", dout_b[3], exp_mem[a2]);
         if (en) rd_addr++;
         if (rd_addr >= 1024 && !en) drain++;
      end
      check_eq("strm_all_read", rd_addr, 32'd1024);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
